// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_arbiter                                                   |
// | Brief    : Round-robin sharing of the EXE-stage ALU between the EXE      |
// |            pipeline (requester 0) and the address/aux unit (requester 1).|
// |            Holds one registered response slot and the architectural     |
// |            {N,Z,C,V} flag register fed back to the ALU as status_in.     |
// | Options  : ALU_ARB_PERF_EN adds saturating per-requester grant counters  |
// |            (grant_cnt0 / grant_cnt1).                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_arbiter #(
   parameter int unsigned CNT_W     = 16,
   parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [3:0]        req0_cmd,
   input  logic [31:0]       req0_op1,
   input  logic [31:0]       req0_op2,
   input  logic              req0_s,
   input  logic [3:0]        req1_cmd,
   input  logic [31:0]       req1_op1,
   input  logic [31:0]       req1_op2,
   input  logic              req1_s,
   output logic [3:0]        alu_command,
   output logic [31:0]       alu_op1,
   output logic [31:0]       alu_op2,
   output logic [3:0]        alu_status_in,
   input  logic [31:0]       alu_result,
   input  logic [3:0]        alu_status,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [31:0]       rsp_result,
   output logic [3:0]        rsp_status,
   output logic [3:0]        flags
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
`endif
);

   localparam logic [3:0] c_cmd_mov = 4'b0001;
   localparam logic [3:0] c_cmd_mvn = 4'b1001;
   localparam logic [3:0] c_cmd_add = 4'b0010;
   localparam logic [3:0] c_cmd_adc = 4'b0011;
   localparam logic [3:0] c_cmd_sub = 4'b0100;
   localparam logic [3:0] c_cmd_sbc = 4'b0101;
   localparam logic [3:0] c_cmd_and = 4'b0110;
   localparam logic [3:0] c_cmd_orr = 4'b0111;
   localparam logic [3:0] c_cmd_eor = 4'b1000;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t      r_state;
   logic [3:0]  r_flags;
   logic        r_last_grant;

   logic        w_can_issue;
   logic [1:0]  w_grant;
   logic        w_any_grant;
   logic        w_sel;
   logic        w_req_s;
   logic        w_supported;

   // A new op may issue when the slot is empty or is being drained this cycle.
   assign w_can_issue = (r_state == ST_IDLE) || rsp_ready;

   // Round-robin grant: a tie goes to the requester that did not win last time.
   always_comb begin
      w_grant = 2'b00;
      if (!rst && w_can_issue) begin
         case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end
   end

   assign w_any_grant = |w_grant;
   assign w_sel       = w_grant[1];
   assign req_ready   = w_grant;

   // Requester 0 drives the ALU whenever requester 1 is not granted.
   assign alu_command   = w_sel ? req1_cmd : req0_cmd;
   assign alu_op1       = w_sel ? req1_op1 : req0_op1;
   assign alu_op2       = w_sel ? req1_op2 : req0_op2;
   assign w_req_s       = w_sel ? req1_s   : req0_s;
   assign alu_status_in = r_flags;

   // Decode of the commands this ALU actually implements.
   always_comb begin
      case (alu_command)
         c_cmd_mov, c_cmd_mvn, c_cmd_add, c_cmd_adc, c_cmd_sub,
         c_cmd_sbc, c_cmd_and, c_cmd_orr, c_cmd_eor: w_supported = 1'b1;
         default:                                    w_supported = 1'b0;
      endcase
   end

   assign rsp_valid = (r_state == ST_FULL);
   assign flags     = r_flags;

   // Slot FSM: captures the granted op's result/status and updates flags on S.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         rsp_id       <= 1'b0;
         rsp_result   <= 32'd0;
         rsp_status   <= 4'd0;
         r_flags      <= FLAGS_RST;
         r_last_grant <= 1'b1;
      end else begin
         if (w_any_grant) begin
            r_state      <= ST_FULL;
            rsp_id       <= w_sel;
            r_last_grant <= w_sel;
            if (w_supported) begin
               rsp_result <= alu_result;
               rsp_status <= alu_status;
               if (w_req_s) begin
                  r_flags <= alu_status;
               end
            end else begin
               // Unknown opcodes complete with a zero result and the current flags.
               rsp_result <= 32'd0;
               rsp_status <= r_flags;
            end
         end else if ((r_state == ST_FULL) && rsp_ready) begin
            r_state <= ST_IDLE;
         end
      end
   end

`ifdef ALU_ARB_PERF_EN
   // Saturating grant counters per requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (w_grant[0] && (grant_cnt0 != {CNT_W{1'b1}})) begin
            grant_cnt0 <= grant_cnt0 + 1'b1;
         end
         if (w_grant[1] && (grant_cnt1 != {CNT_W{1'b1}})) begin
            grant_cnt1 <= grant_cnt1 + 1'b1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_arbiter                                                |
// | Brief    : Self-checking bench for alu_arbiter with a behavioural ALU    |
// |            and a response scoreboard queue.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;

   localparam int unsigned CNT_W     = 16;
   localparam logic [3:0]  FLAGS_RST = 4'b0000;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [3:0]        req0_cmd, req1_cmd;
   logic [31:0]       req0_op1, req0_op2, req1_op1, req1_op2;
   logic              req0_s, req1_s;
   logic [3:0]        alu_command, alu_status_in, alu_status;
   logic [31:0]       alu_op1, alu_op2, alu_result;
   logic              rsp_valid, rsp_ready, rsp_id;
   logic [31:0]       rsp_result;
   logic [3:0]        rsp_status, flags;
`ifdef ALU_ARB_PERF_EN
   logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;
   logic [CNT_W-1:0]  m_cnt0 = '0;
   logic [CNT_W-1:0]  m_cnt1 = '0;
`endif

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic [3:0]  st;
   } rsp_t;

   rsp_t        q[$];
   logic [3:0]  m_flags = FLAGS_RST;
   logic        m_last  = 1'b1;
   logic        rst_d   = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.CNT_W(CNT_W), .FLAGS_RST(FLAGS_RST)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req0_cmd      (req0_cmd),
      .req0_op1      (req0_op1),
      .req0_op2      (req0_op2),
      .req0_s        (req0_s),
      .req1_cmd      (req1_cmd),
      .req1_op1      (req1_op1),
      .req1_op2      (req1_op2),
      .req1_s        (req1_s),
      .alu_command   (alu_command),
      .alu_op1       (alu_op1),
      .alu_op2       (alu_op2),
      .alu_status_in (alu_status_in),
      .alu_result    (alu_result),
      .alu_status    (alu_status),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_result    (rsp_result),
      .rsp_status    (rsp_status),
`ifdef ALU_ARB_PERF_EN
      .grant_cnt0    (grant_cnt0),
      .grant_cnt1    (grant_cnt1),
`endif
      .flags         (flags)
   );

   // Behavioural ALU: logical ops keep C/V, arithmetic ops compute them.
   function automatic logic [35:0] alu_fn(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] st);
      logic [32:0] w;
      logic [31:0] r;
      logic        c, v;
      c = st[1];
      v = st[0];
      r = 32'd0;
      w = 33'd0;
      case (cmd)
         4'b0001: r = b;
         4'b1001: r = ~b;
         4'b0010, 4'b0011: begin
            w = {1'b0, a} + {1'b0, b} + {32'd0, (cmd == 4'b0011) ? st[1] : 1'b0};
            r = w[31:0];
            c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'b0100, 4'b0101: begin
            w = {1'b0, a} - {1'b0, b} - {32'd0, (cmd == 4'b0101) ? ~st[1] : 1'b0};
            r = w[31:0];
            c = ~w[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'b0110: r = a & b;
         4'b0111: r = a | b;
         4'b1000: r = a ^ b;
         default: return {4'b1111, 32'hDEAD_BEEF};
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   function automatic logic supported(input logic [3:0] cmd);
      return (cmd >= 4'd1) && (cmd <= 4'd9);
   endfunction

   assign {alu_status, alu_result} = alu_fn(alu_command, alu_op1, alu_op2, alu_status_in);

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model and scoreboard, evaluated mid-cycle when inputs are stable.
   always @(negedge clk) begin
      logic [1:0]  eg;
      logic        can;
      logic        sel;
      logic [35:0] e;
      rsp_t        ent;
      if (rst) begin
         check_val("ready_in_rst", {62'd0, req_ready}, 64'd0);
         if (rst_d) begin
            check_val("rsp_valid_rst", {63'd0, rsp_valid}, 64'd0);
            check_val("flags_rst", {60'd0, flags}, {60'd0, FLAGS_RST});
         end
         q.delete();
         m_flags = FLAGS_RST;
         m_last  = 1'b1;
`ifdef ALU_ARB_PERF_EN
         m_cnt0 = '0;
         m_cnt1 = '0;
`endif
      end else begin
         can = (q.size() == 0) || rsp_ready;
         eg  = 2'b00;
         if (can) begin
            if (req_valid == 2'b01)      eg = 2'b01;
            else if (req_valid == 2'b10) eg = 2'b10;
            else if (req_valid == 2'b11) eg = m_last ? 2'b01 : 2'b10;
         end
         check_val("req_ready", {62'd0, req_ready}, {62'd0, eg});
         check_val("rsp_valid", {63'd0, rsp_valid}, {63'd0, (q.size() != 0)});
         check_val("flags", {60'd0, flags}, {60'd0, m_flags});
`ifdef ALU_ARB_PERF_EN
         check_val("grant_cnt0", {{(64-CNT_W){1'b0}}, grant_cnt0}, {{(64-CNT_W){1'b0}}, m_cnt0});
         check_val("grant_cnt1", {{(64-CNT_W){1'b0}}, grant_cnt1}, {{(64-CNT_W){1'b0}}, m_cnt1});
`endif
         if (q.size() != 0) begin
            check_val("rsp_id", {63'd0, rsp_id}, {63'd0, q[0].id});
            check_val("rsp_result", {32'd0, rsp_result}, {32'd0, q[0].res});
            check_val("rsp_status", {60'd0, rsp_status}, {60'd0, q[0].st});
            if (rsp_ready) void'(q.pop_front());
         end
         if (eg != 2'b00) begin
            sel = eg[1];
            ent.id = sel;
            if (!sel) begin
               e = alu_fn(req0_cmd, req0_op1, req0_op2, m_flags);
               if (supported(req0_cmd)) begin
                  ent.res = e[31:0];
                  ent.st  = e[35:32];
                  if (req0_s) m_flags = e[35:32];
               end else begin
                  ent.res = 32'd0;
                  ent.st  = m_flags;
               end
            end else begin
               e = alu_fn(req1_cmd, req1_op1, req1_op2, m_flags);
               if (supported(req1_cmd)) begin
                  ent.res = e[31:0];
                  ent.st  = e[35:32];
                  if (req1_s) m_flags = e[35:32];
               end else begin
                  ent.res = 32'd0;
                  ent.st  = m_flags;
               end
            end
            q.push_back(ent);
            m_last = sel;
`ifdef ALU_ARB_PERF_EN
            if (!sel && (m_cnt0 != {CNT_W{1'b1}})) m_cnt0 = m_cnt0 + 1'b1;
            if (sel  && (m_cnt1 != {CNT_W{1'b1}})) m_cnt1 = m_cnt1 + 1'b1;
`endif
         end
      end
      rst_d = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed scenarios followed by a random phase.
   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
      req0_cmd = 4'd0; req0_op1 = 32'd0; req0_op2 = 32'd0; req0_s = 1'b0;
      req1_cmd = 4'd0; req1_op1 = 32'd0; req1_op2 = 32'd0; req1_s = 1'b0;
      tick();
      tick();
      check_val("rst_valid", {63'd0, rsp_valid}, 64'd0);
      check_val("rst_flags", {60'd0, flags}, {60'd0, FLAGS_RST});
      check_val("rst_ready", {62'd0, req_ready}, 64'd0);
      check_val("rst_id", {63'd0, rsp_id}, 64'd0);
      check_val("rst_result", {32'd0, rsp_result}, 64'd0);
      check_val("rst_status", {60'd0, rsp_status}, 64'd0);

      // First tie after reset goes to requester 0.
      rst = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
      req0_cmd = 4'b0010; req0_op1 = 32'hFFFF_FFFF; req0_op2 = 32'h1; req0_s = 1'b1;
      req1_cmd = 4'b0011; req1_op1 = 32'd5; req1_op2 = 32'd3; req1_s = 1'b1;
      #1;
      check_val("first_tie", {62'd0, req_ready}, 64'h1);
      tick();
      check_val("add_valid", {63'd0, rsp_valid}, 64'd1);
      check_val("add_result", {32'd0, rsp_result}, 64'd0);
      check_val("add_flags", {60'd0, flags}, 64'h6);
      check_val("add_id", {63'd0, rsp_id}, 64'd0);
      check_val("adc_ready", {62'd0, req_ready}, 64'h2);
      tick();
      check_val("adc_result", {32'd0, rsp_result}, 64'd9);
      check_val("adc_id", {63'd0, rsp_id}, 64'd1);

      // Alternating grants with both requesters busy.
      req0_cmd = 4'b0100; req0_op1 = 32'd100; req0_op2 = 32'd7; req0_s = 1'b0;
      req1_cmd = 4'b1000; req1_op1 = 32'hF0F0_F0F0; req1_op2 = 32'h0FF0_0FF0; req1_s = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check_val("alt_ready", {62'd0, req_ready}, (i % 2 == 0) ? 64'h1 : 64'h2);
         tick();
         check_val("alt_id", {63'd0, rsp_id}, (i % 2 == 0) ? 64'd0 : 64'd1);
      end

      // Back-pressure: nothing issues while the slot is held.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("hold_ready", {62'd0, req_ready}, 64'd0);
         tick();
         check_val("hold_valid", {63'd0, rsp_valid}, 64'd1);
      end
      rsp_ready = 1'b1;
      #1;
      check_val("release_grant", {62'd0, req_ready}, 64'h1);
      tick();

      // Unsupported opcode leaves flags alone even with S set.
      req_valid = 2'b01;
      req0_cmd = 4'b0010; req0_op1 = 32'd0; req0_op2 = 32'd0; req0_s = 1'b1;
      tick();
      req0_cmd = 4'b0001; req0_op2 = 32'h8000_0000;
      tick();
      check_val("mov_flags", {60'd0, flags}, 64'h8);
      req0_cmd = 4'b1111; req0_op1 = 32'h1234; req0_op2 = 32'h5678;
      tick();
      check_val("bad_result", {32'd0, rsp_result}, 64'd0);
      check_val("bad_flags", {60'd0, flags}, 64'h8);
      check_val("bad_status", {60'd0, rsp_status}, 64'h8);
      req_valid = 2'b00; rsp_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check_val("rst_drop", {63'd0, rsp_valid}, 64'd0);
      rst = 1'b0;

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         req_valid = 2'($urandom_range(3, 0));
         rsp_ready = ($urandom_range(3, 0) != 0);
         req0_cmd  = 4'($urandom_range(15, 0));
         req1_cmd  = 4'($urandom_range(15, 0));
         req0_op1  = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
         req0_op2  = ($urandom_range(3, 0) == 0) ? 32'd1 : $urandom;
         req1_op1  = ($urandom_range(3, 0) == 0) ? 32'h8000_0000 : $urandom;
         req1_op2  = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
         req0_s    = 1'($urandom_range(1, 0));
         req1_s    = 1'($urandom_range(1, 0));
         rst       = ($urandom_range(63, 0) == 0);
         tick();
      end
      rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
